// File: rtl/key_gesture_pkg.sv
// Shared types and default timing constants for the key gesture classifier.
// States are one-hot; counts assume a 50 MHz clock.
package key_gesture_pkg;

   localparam int LONG_CNT_DEF = 75_000_000;
   localparam int DBL_CNT_DEF  = 15_000_000;
   localparam int RPT_CNT_DEF  = 10_000_000;
   localparam int CNT_W_DEF    = 27;

   typedef enum logic [4:0] {
      ST_IDLE   = 5'b00001,
      ST_PRESS1 = 5'b00010,
      ST_WAIT2  = 5'b00100,
      ST_PRESS2 = 5'b01000,
      ST_LHOLD  = 5'b10000
   } state_e;

endpackage

// File: rtl/key_gesture_timer.sv
// Saturating up-counter with synchronous clear, enable and terminal compare.
// Ports: clk, rst_n, clr, en, limit[CNT_W-1:0] in; tc out (cnt == limit).
module key_gesture_timer
   import key_gesture_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             tc
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == limit);

endmodule

// File: rtl/key_gesture_ctrl.sv
// Click / double-click / long-press classifier behind the key debouncer.
// Ports: clk, rst_n, key_status (0=pressed), key_event in; click_pulse,
// dbl_pulse, long_pulse, rpt_pulse, busy out (all registered).
// Macro KEY_GESTURE_REPEAT_EN enables auto-repeat ticks in LONG_HOLD.
module key_gesture_ctrl
   import key_gesture_pkg::*;
#(
   parameter int LONG_CNT = LONG_CNT_DEF,
   parameter int DBL_CNT  = DBL_CNT_DEF,
   parameter int RPT_CNT  = RPT_CNT_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_status,
   input  logic key_event,
   output logic click_pulse,
   output logic dbl_pulse,
   output logic long_pulse,
   output logic rpt_pulse,
   output logic busy
);

   state_e state_q;
   state_e state_d;

   logic click_q, click_d;
   logic dbl_q, dbl_d;
   logic long_q, long_d;
   logic busy_q, busy_d;

   logic press;
   logic rel;
   logic tc;
   logic t_clr;
   logic t_en;
   logic [CNT_W-1:0] t_limit;

   assign press = key_event & ~key_status;
   assign rel   = key_event & key_status;

`ifdef KEY_GESTURE_REPEAT_EN
   logic rpt_q, rpt_d;
`endif

   always_comb begin
      state_d = state_q;
      click_d = 1'b0;
      dbl_d   = 1'b0;
      long_d  = 1'b0;
`ifdef KEY_GESTURE_REPEAT_EN
      rpt_d   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (press) state_d = ST_PRESS1;
         end
         ST_PRESS1: begin
            // release beats the long-press terminal count
            if (rel) begin
               state_d = ST_WAIT2;
            end else if (tc) begin
               long_d  = 1'b1;
               state_d = ST_LHOLD;
            end
         end
         ST_WAIT2: begin
            // second press beats the double-click timeout
            if (press) begin
               state_d = ST_PRESS2;
            end else if (tc) begin
               click_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_PRESS2: begin
            if (rel) begin
               dbl_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_LHOLD: begin
            if (rel) begin
               state_d = ST_IDLE;
            end
`ifdef KEY_GESTURE_REPEAT_EN
            else if (tc) begin
               rpt_d = 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // Counter restarts on every state change; in LONG_HOLD with repeat
   // it also wraps at each tick so the period stays RPT_CNT cycles.
   always_comb begin
      t_clr = (state_d != state_q);
`ifdef KEY_GESTURE_REPEAT_EN
      t_clr = t_clr | rpt_d;
`endif
      t_en = (state_q == ST_PRESS1) |
             (state_q == ST_WAIT2)  |
             (state_q == ST_LHOLD);
      case (state_q)
         ST_PRESS1: t_limit = CNT_W'(LONG_CNT - 1);
         ST_WAIT2:  t_limit = CNT_W'(DBL_CNT - 1);
         ST_LHOLD:  t_limit = CNT_W'(RPT_CNT - 1);
         default:   t_limit = '1;
      endcase
   end

   key_gesture_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (t_clr),
      .en    (t_en),
      .limit (t_limit),
      .tc    (tc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         click_q <= 1'b0;
         dbl_q   <= 1'b0;
         long_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         click_q <= click_d;
         dbl_q   <= dbl_d;
         long_q  <= long_d;
         busy_q  <= busy_d;
      end
   end

`ifdef KEY_GESTURE_REPEAT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rpt_q <= 1'b0;
      end else begin
         rpt_q <= rpt_d;
      end
   end
   assign rpt_pulse = rpt_q;
`else
   assign rpt_pulse = 1'b0;
`endif

   assign click_pulse = click_q;
   assign dbl_pulse   = dbl_q;
   assign long_pulse  = long_q;
   assign busy        = busy_q;

endmodule
